// File: rtl/dft_pkg.sv
// Shared DFT constants and the scan-flop input mux used by every scan chain.
package dft_pkg;

  localparam logic SCAN_MODE    = 1'b1;
  localparam logic FUNC_MODE    = 1'b0;
  localparam logic RESET_ACTIVE = 1'b0;

  // Selects the serial input in scan mode, the functional input otherwise.
  function automatic logic scan_mux(input logic tst, input logic d, input logic si);
    logic r;
    r = d;
    case (tst)
      FUNC_MODE: r = d;
      SCAN_MODE: r = si;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scan_flop.sv
// One scan flip-flop: functional/scan mux in front of an async active-low reset DFF.
module scan_flop
  import dft_pkg::*;
(
  input  logic clk,
  input  logic RESET,
  input  logic TST,
  input  logic D,
  input  logic SI,
  output logic Q
);

  logic q_q;
  logic q_d;

  always_comb q_d = scan_mux(TST, D, SI);

  always_ff @(posedge clk or negedge RESET) begin
    if (RESET == RESET_ACTIVE) q_q <= 1'b0;
    else                       q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/scannable_chain_4_bit.sv
// Parallel-load register that turns into a TDI->TDO shift chain in test mode.
module scannable_chain_4_bit
  import dft_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             TST,
  input  logic             TDI,
  input  logic [WIDTH-1:0] Data_in,
  output logic             TDO,
  output logic [WIDTH-1:0] Data_out
);

  logic [WIDTH-1:0] chain_q;
  logic [WIDTH-1:0] si_d;

  // Bit 0 takes TDI; every other bit takes its lower neighbour.
  always_comb begin
    si_d = '0;
    si_d[0] = TDI;
    for (int i = 1; i < WIDTH; i++) si_d[i] = chain_q[i-1];
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    scan_flop u_flop (
      .clk   (clk),
      .RESET (RESET),
      .TST   (TST),
      .D     (Data_in[g]),
      .SI    (si_d[g]),
      .Q     (chain_q[g])
    );
  end

  assign Data_out = chain_q;
  assign TDO      = chain_q[WIDTH-1];

endmodule

// File: tb/tb_scannable_chain_4_bit.sv
// Directed bench for the 4-bit scan chain with an expected-value queue.
module tb_scannable_chain_4_bit;

  logic       clk;
  logic       RESET;
  logic       TST;
  logic       TDI;
  logic [3:0] Data_in;
  logic       TDO;
  logic [3:0] Data_out;

  typedef struct {
    logic [3:0] dout;
    logic       tdo;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  scannable_chain_4_bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .TST      (TST),
    .TDI      (TDI),
    .Data_in  (Data_in),
    .TDO      (TDO),
    .Data_out (Data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [3:0] dout, input logic tdo);
    exp_t e;
    e.dout = dout;
    e.tdo  = tdo;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty: got no entry, want one");
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    assert (Data_out === e.dout && TDO === e.tdo)
      else begin
        n_bad++;
        $error("FAIL %s: got dout=%h tdo=%b, want dout=%h tdo=%b",
               e.tag, Data_out, TDO, e.dout, e.tdo);
      end
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic step(input string tag, input logic tst, input logic tdi,
                      input logic [3:0] din, input logic [3:0] dout_exp);
    TST     = tst;
    TDI     = tdi;
    Data_in = din;
    push(tag, dout_exp, dout_exp[3]);
    @(posedge clk);
    @(negedge clk);
    pop_check();
  endtask

  // Compare the current outputs without a clock edge.
  task automatic now_check(input string tag, input logic [3:0] dout_exp, input logic tdo_exp);
    push(tag, dout_exp, tdo_exp);
    pop_check();
  endtask

  initial begin
    RESET   = 1'b0;
    TST     = 1'b0;
    TDI     = 1'b0;
    Data_in = 4'hF;
    #1;
    now_check("reset_t0", 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      now_check("reset_hold", 4'h0, 1'b0);
    end

    RESET = 1'b1;
    step("release_capture", 1'b0, 1'b0, 4'hF, 4'hF);

    step("capture_2", 1'b0, 1'b0, 4'h2, 4'h2);
    step("capture_9", 1'b0, 1'b0, 4'h9, 4'h9);

    // Shift ones in starting from 4'h2; Data_in must be ignored while scanning.
    step("capture_2b", 1'b0, 1'b0, 4'h2, 4'h2);
    step("shin_1", 1'b1, 1'b1, 4'h0, 4'h5);
    step("shin_2", 1'b1, 1'b1, 4'h0, 4'hB);
    step("shin_3", 1'b1, 1'b1, 4'h0, 4'h7);
    step("shin_4", 1'b1, 1'b1, 4'h0, 4'hF);

    // Shift 4'hA out on TDO: 1,0,1,0.
    step("capture_A", 1'b0, 1'b0, 4'hA, 4'hA);
    now_check("shout_tdo0", 4'hA, 1'b1);
    step("shout_1", 1'b1, 1'b0, 4'hF, 4'h4);
    now_check("shout_tdo1", 4'h4, 1'b0);
    step("shout_2", 1'b1, 1'b0, 4'hF, 4'h8);
    now_check("shout_tdo2", 4'h8, 1'b1);
    step("shout_3", 1'b1, 1'b0, 4'hF, 4'h0);
    now_check("shout_tdo3", 4'h0, 1'b0);
    step("shout_4", 1'b1, 1'b0, 4'hF, 4'h0);

    // A single 1 on TDI reaches TDO after exactly 4 edges.
    step("walk_1", 1'b1, 1'b1, 4'h0, 4'h1);
    step("walk_2", 1'b1, 1'b0, 4'h0, 4'h2);
    step("walk_3", 1'b1, 1'b0, 4'h0, 4'h4);
    step("walk_4", 1'b1, 1'b0, 4'h0, 4'h8);

    // Asynchronous reset between edges while scanning.
    step("capture_F", 1'b0, 1'b0, 4'hF, 4'hF);
    TST = 1'b1;
    TDI = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    now_check("async_reset", 4'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    now_check("async_reset_hold", 4'h0, 1'b0);
    RESET = 1'b1;
    step("post_reset_shift", 1'b1, 1'b1, 4'h0, 4'h1);

    // Capture->scan->capture.
    step("capture_5", 1'b0, 1'b0, 4'h5, 4'h5);
    step("switch_scan", 1'b1, 1'b0, 4'hC, 4'hA);
    step("switch_func", 1'b0, 1'b1, 4'h3, 4'h3);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
